// File: rtl/hex_scan_display_pkg.sv
// Shared types and constants for the hex/decimal scanned display.
package hex_scan_display_pkg;

    localparam int DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Active-low seven-segment glyph {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_scan_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, 32 in all.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic        done
);

    logic [31:0] sh;
    logic [4:0]  cnt;
    logic        run;
    logic [39:0] adj;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 10; i++)
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end

    // High during the cycle whose edge performs the final iteration, so the
    // sequencer can leave its shift state exactly as the result settles.
    assign done = run && (cnt == 5'd31);

    // Load on start, then iterate until 32 shifts are done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            {bcd, sh} <= {adj[38:0], sh, 1'b0};
            cnt       <= cnt + 5'd1;
            if (cnt == 5'd31)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/hex_scan_display.sv
// Eight-digit multiplexed seven-segment driver showing a 32-bit value in hex
// or unsigned decimal; decimal goes through a sequential BCD converter.
module hex_scan_display
    import hex_scan_display_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        mode,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        busy,
    output logic        overflow
);

    localparam int PW = $clog2(CLK_DIV);

    state_t                  state;
    logic [31:0]             shown_val;
    logic                    shown_mode;
    logic                    changed;
    logic                    start;
    logic [39:0]             bcd;
    logic                    cvt_done;
    logic [DIGITS-1:0][3:0]  digs;
    logic [DIGITS-1:0]       blank;
    logic [DIGITS-1:0][3:0]  nxt_digs;
    logic [DIGITS-1:0]       nxt_blank;
    logic                    nxt_ovf;
    logic                    lead;
    logic [PW-1:0]           pres;
    logic [2:0]              idx;

    assign changed = (data_in != shown_val) || (mode != shown_mode);
    assign start   = (state == IDLE) && changed && mode;

    bin2bcd_seq u_b2b (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (data_in),
        .bcd   (bcd),
        .done  (cvt_done)
    );

    // Digits, blanking and overflow to commit; leading zeros are judged over
    // all ten BCD digits so an overflowed value never blanks its low digits.
    always_comb begin
        nxt_digs  = shown_val;
        nxt_blank = '0;
        nxt_ovf   = 1'b0;
        lead      = 1'b0;
        if (shown_mode) begin
            nxt_digs = bcd[31:0];
            nxt_ovf  = |bcd[39:32];
            lead     = !nxt_ovf;
            for (int i = DIGITS-1; i > 0; i--) begin
                lead         = lead && (bcd[i*4 +: 4] == 4'd0);
                nxt_blank[i] = lead;
            end
        end
    end

    // Control FSM: detect a new value/mode, convert if decimal, commit in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shown_val  <= '0;
            shown_mode <= 1'b0;
            busy       <= 1'b0;
            digs       <= '0;
            blank      <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (changed) begin
                    shown_val  <= data_in;
                    shown_mode <= mode;
                    busy       <= 1'b1;
                    state      <= mode ? SHIFT : DONE;
                end
                SHIFT: if (cvt_done) state <= DONE;
                DONE: begin
                    digs     <= nxt_digs;
                    blank    <= nxt_blank;
                    overflow <= nxt_ovf;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaled digit scan; outputs register the digit selected before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pres <= '0;
            idx  <= '0;
            AN   <= 8'hFF;
            SEG  <= 7'h7F;
            DP   <= 1'b1;
        end else begin
            if (pres == PW'(CLK_DIV-1)) begin
                pres <= '0;
                idx  <= idx + 3'd1;
            end else begin
                pres <= pres + 1'b1;
            end
            AN  <= ~(8'd1 << idx);
            SEG <= blank[idx] ? 7'h7F : glyph(digs[idx]);
            DP  <= !(overflow && (idx == 3'(DIGITS-1)));
        end
    end

endmodule
